cselector_n_mmu: RTL

Clocked, parametrised N-way token selector for the MMU handshake fabric; it is the synchronous successor to the two-way click-based selector. A token (drive pulse plus payload and select mask) is buffered in a DEPTH-entry FIFO, issued as drive pulses to one or more selected downstream ports (multicast), and retired when the downstream frees satisfy the configured join rule. Each retirement returns one free pulse upstream.

---
 rtl/cselector_n_mmu.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cselector_n_mmu.sv
// N-way clocked token selector: buffers tokens in a small FIFO, multicasts drive
// pulses to the selected ports and retires the head once the join rule is met.
module cselector_n_mmu #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int JOIN_ALL   = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         i_drive,
  input  logic [NUM_PORTS-1:0]         i_select,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic                         o_free,
  output logic                         o_full,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [NUM_PORTS-1:0]         o_driveNext,
  output logic [DATA_WIDTH-1:0]        o_data,
  input  logic [NUM_PORTS-1:0]         i_freeNext,
  output logic                         o_err
);

  // state | meaning
  // IDLE  | FIFO empty, outputs quiet
  // ISSUE | single cycle, head mask on o_driveNext
  // WAIT  | head issued, collecting frees on pending ports
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  state_t                  state, state_nxt;
  logic [NUM_PORTS-1:0]    mem_mask [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_data [DEPTH];
  logic [AW-1:0]           rd_ptr, wr_ptr;
  logic [CW-1:0]           count, count_nxt, remain;
  logic [NUM_PORTS-1:0]    pending, pending_nxt, legal, head_mask, drive_nxt;
  logic                    push, pop, zero_err, err_nxt;

  assign head_mask = mem_mask[rd_ptr];

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    legal       = '0;
    pop         = 1'b0;
    zero_err    = 1'b0;
    drive_nxt   = '0;
    push        = i_drive && !o_full;

    case (state)
      IDLE: begin
        if (push) state_nxt = ISSUE;
      end
      ISSUE: begin
        legal       = head_mask;
        pending_nxt = head_mask & ~i_freeNext;
        if (head_mask == '0) begin
          pop      = 1'b1;
          zero_err = 1'b1;
        end else if (JOIN_ALL != 0) begin
          pop = (pending_nxt == '0);
        end else begin
          pop = |(head_mask & i_freeNext);
        end
        if (!pop) state_nxt = WAIT;
      end
      WAIT: begin
        legal       = pending;
        pending_nxt = pending & ~i_freeNext;
        if (JOIN_ALL != 0) pop = (pending_nxt == '0);
        else               pop = |(pending & i_freeNext);
      end
      default: state_nxt = IDLE;
    endcase

    count_nxt = count + CW'(push) - CW'(pop);
    remain    = count - CW'(pop);
    if (pop) begin
      pending_nxt = '0;
      state_nxt   = (count_nxt != '0) ? ISSUE : IDLE;
    end

    // New head may be the token being pushed on this very edge.
    if (state_nxt == ISSUE)
      drive_nxt = (remain == '0) ? i_select : mem_mask[rd_ptr + AW'(pop)];

    err_nxt = (i_drive && o_full) || (|(i_freeNext & ~legal)) || zero_err;
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_mask[wr_ptr] <= i_select;
      mem_data[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      pending     <= '0;
      o_free      <= 1'b0;
      o_full      <= 1'b0;
      o_driveNext <= '0;
      o_err       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      o_full      <= (count_nxt == CW'(DEPTH));
      pending     <= pending_nxt;
      o_free      <= pop;
      o_driveNext <= drive_nxt;
      o_err       <= err_nxt;
    end
  end

  assign o_count = count;
  assign o_data  = (count == '0) ? '0 : mem_data[rd_ptr];

endmodule
